// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, coefficient reset value and guard-bit helper for fir_prog
package fir_pkg;
  localparam int DEF_TAPS = 5;
  localparam int DEF_IW = 4;
  localparam int DEF_CW = 4;
  localparam int DEF_OW = 16;
  localparam int COEF_RST = 1;
  function automatic int guard_bits(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/fir_tap.sv
// fir_tap: one lane holding a programmable coefficient and its registered full-width product
module fir_tap import fir_pkg::*; #(
  parameter int IW = DEF_IW,
  parameter int CW = DEF_CW,
  parameter int AW = 3,
  parameter int IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 load,
  input  logic signed [IW-1:0] sample,
  output logic signed [IW+CW-1:0] prod
);
  logic signed [CW-1:0] coef;
  logic signed [IW+CW-1:0] prod_d;
  REGISTER_R #(.N(CW), .INIT(CW'(COEF_RST))) u_coef (
    .clk, .rst, .ce(coef_we && coef_addr == AW'(IDX)), .d(coef_data), .q(coef));
  assign prod_d = sample * coef;
  REGISTER_R #(.N(IW+CW)) u_prod (.clk, .rst, .ce(load), .d(prod_d), .q(prod));
endmodule

// File: rtl/register_r.sv
// REGISTER_R: clock-enabled register with asynchronous active-high reset to INIT
module REGISTER_R #(
  parameter int N = 1,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT;
    else if (ce) q <= d;
endmodule

// File: rtl/fir_prog.sv
// fir_prog: two-stage programmable FIR with valid/ready handshake; FIR_PROG_SATURATE_EN clamps instead of wrapping
module fir_prog import fir_pkg::*; #(
  parameter int NUM_TAPS = DEF_TAPS,
  parameter int NUM_INPUT_BITS = DEF_IW,
  parameter int NUM_COEF_BITS = DEF_CW,
  parameter int NUM_OUTPUT_BITS = DEF_OW
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [NUM_INPUT_BITS-1:0]    In,
  input  logic                                coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]         coef_addr,
  input  logic signed [NUM_COEF_BITS-1:0]     coef_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [NUM_OUTPUT_BITS-1:0]   Out
);
  localparam int IW = NUM_INPUT_BITS;
  localparam int OW = NUM_OUTPUT_BITS;
  localparam int PW = NUM_INPUT_BITS + NUM_COEF_BITS;
  localparam int SW = PW + guard_bits(NUM_TAPS);
  localparam int AW = $clog2(NUM_TAPS);
  logic advance, accept, v1;
  logic signed [IW-1:0] tap [NUM_TAPS];
  logic signed [IW-1:0] shifted [NUM_TAPS];
  logic signed [PW-1:0] prod [NUM_TAPS];
  logic signed [SW-1:0] sum;
  logic signed [OW-1:0] out_d;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept = in_valid && advance;
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_lane
    if (k == 0) begin : g_head
      assign shifted[k] = In;
    end else begin : g_body
      assign shifted[k] = tap[k-1];
    end
    REGISTER_R #(.N(IW)) u_dl (.clk, .rst, .ce(accept), .d(shifted[k]), .q(tap[k]));
    fir_tap #(.IW(IW), .CW(NUM_COEF_BITS), .AW(AW), .IDX(k)) u_tap (
      .clk, .rst, .coef_we, .coef_addr, .coef_data,
      .load(accept), .sample(shifted[k]), .prod(prod[k]));
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) sum = sum + SW'(prod[i]);
  end
`ifdef FIR_PROG_SATURATE_EN
  localparam int EW = SW > OW ? SW : OW;
  localparam logic signed [EW-1:0] HI = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] LO = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic signed [EW-1:0] sx;
  assign sx = EW'(sum);
  assign out_d = sx > HI ? OW'(HI) : sx < LO ? OW'(LO) : OW'(sx);
`else
  assign out_d = OW'(sum);
`endif
  // Stage 2 loads only real results so Out keeps the last one while idle
  REGISTER_R #(.N(1)) u_v1 (.clk, .rst, .ce(advance), .d(accept), .q(v1));
  REGISTER_R #(.N(OW)) u_out (.clk, .rst, .ce(advance && v1), .d(out_d), .q(Out));
  REGISTER_R #(.N(1)) u_ov (.clk, .rst, .ce(advance), .d(v1), .q(out_valid));
endmodule

// File: tb/tb_fir_prog.sv
// tb_fir_prog: directed self-checking bench for fir_prog (5 taps, 4-bit data, 8-bit output)
module tb_fir_prog;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic in_ready;
  logic signed [3:0] In = 0;
  logic coef_we = 0;
  logic [2:0] coef_addr = 0;
  logic signed [3:0] coef_data = 0;
  logic out_valid;
  logic out_ready = 0;
  logic signed [7:0] Out;
  int errors = 0;
  int checks = 0;
  int h [6] = '{2, -1, 3, 0, 1, 0};
  int w [5] = '{6, 4, 4, 3, 1};
  fir_prog #(.NUM_TAPS(5), .NUM_INPUT_BITS(4), .NUM_COEF_BITS(4), .NUM_OUTPUT_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .In(In),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic pulse_rst();
    rst = 1;
    #1;
    rst = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic signed [3:0] d);
    coef_we = 1;
    coef_addr = a;
    coef_data = d;
    step();
    coef_we = 0;
  endtask
  initial begin
    #1 rst = 1;
    #1;
    check("rst_out", Out, 0);
    check("rst_ov", out_valid, 0);
    step();
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    // moving sum with default coefficients
    out_ready = 1;
    in_valid = 1;
    for (int i = 1; i <= 5; i++) begin
      In = 4'(i);
      step();
      if (i >= 2) check("mavg", Out, (i - 1) * i / 2);
    end
    in_valid = 0;
    step();
    check("mavg_last", Out, 15);
    check("mavg_ov", out_valid, 1);
    step();
    check("mavg_drain_ov", out_valid, 0);
    check("mavg_hold", Out, 15);
    // impulse response
    pulse_rst();
    wr(0, 2); wr(1, -1); wr(2, 3); wr(3, 0); wr(4, 1);
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      In = (i == 0) ? 4'sd1 : 4'sd0;
      step();
      if (i >= 1) check("impulse", Out, h[i-1]);
    end
    in_valid = 0;
    step();
    check("impulse_tail", Out, h[5]);
    // backpressure
    pulse_rst();
    in_valid = 1;
    In = 1;
    step();
    In = 2;
    step();
    check("bp_first", Out, 1);
    out_ready = 0;
    In = 3;
    #1;
    check("bp_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_out", Out, 1);
      check("bp_stall_ov", out_valid, 1);
      check("bp_stall_ready", in_ready, 0);
    end
    out_ready = 1;
    step();
    check("bp_resume1", Out, 3);
    In = 4;
    step();
    check("bp_resume2", Out, 6);
    in_valid = 0;
    step();
    check("bp_resume3", Out, 10);
    step();
    check("bp_drain_ov", out_valid, 0);
    // overflow of the 8-bit output
    pulse_rst();
    for (int i = 0; i < 5; i++) wr(3'(i), -8);
    in_valid = 1;
    In = -8;
    step();
    step();
    check("sat_first", Out, 64);
    for (int i = 0; i < 3; i++) step();
    in_valid = 0;
    step();
`ifdef FIR_PROG_SATURATE_EN
    check("sat_full", Out, 127);
`else
    check("sat_full", Out, 64);
`endif
    // coefficient write in the accept cycle and out-of-range address
    pulse_rst();
    in_valid = 1;
    In = 1;
    coef_we = 1;
    coef_addr = 0;
    coef_data = 3;
    step();
    In = 2;
    coef_addr = 7;
    coef_data = 5;
    step();
    coef_we = 0;
    check("wda_old_coef", Out, 1);
    in_valid = 0;
    step();
    check("wda_new_coef", Out, 7);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      In = (i == 0) ? 4'sd1 : 4'sd0;
      step();
      if (i >= 1) check("bad_addr", Out, w[i-1]);
    end
    in_valid = 0;
    step();
    check("bad_addr_tail", Out, w[4]);
    // asynchronous reset between edges
    in_valid = 1;
    In = 2;
    step();
    step();
    check("ar_pre_ov", out_valid, 1);
    #3 rst = 1;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_out", Out, 0);
    #1 rst = 0;
    In = 4;
    step();
    in_valid = 0;
    step();
    check("ar_coef_default", Out, 4);
    check("ar_post_ov", out_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_prog.md
FIR_PROG -- requirements
Module: fir_prog

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 5: number of taps, range 2..16.
REQ-002 SHALL have parameter NUM_INPUT_BITS, default 4: signed sample width.
REQ-003 SHALL have parameter NUM_COEF_BITS, default 4: signed coefficient width.
REQ-004 SHALL have parameter NUM_OUTPUT_BITS, default 16: signed result width, at least NUM_INPUT_BITS+NUM_COEF_BITS.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: the In sample is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-009 SHALL have port In, input, NUM_INPUT_BITS bits, signed: the sample.
REQ-010 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-011 SHALL have port coef_addr, input, $clog2(NUM_TAPS) bits: tap index to write.
REQ-012 SHALL have port coef_data, input, NUM_COEF_BITS bits, signed: coefficient value.
REQ-013 SHALL have port out_valid, output, 1 bit: Out holds a result.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port Out, output, NUM_OUTPUT_BITS bits, signed: the filter result.

Function
REQ-016 SHALL accept a sample on a cycle with in_valid && in_ready; accepted samples shift into the delay line, with tap 0 the newest.
REQ-017 SHALL hold the delay line unchanged on cycles with no accept.
REQ-018 SHALL compute each result as the sum over k of coef[k]*tap[k], using the delay line after the shift.
REQ-019 SHALL pipeline in two stages.
  - Stage 1 registers the NUM_TAPS products.
  - Stage 2 registers the sign-extended sum into Out.
REQ-020 SHALL assert out_valid exactly 2 cycles after an accept when out_ready is held high.
REQ-021 SHALL drive advance = !out_valid || out_ready, and in_ready = advance.
REQ-022 SHALL stall both stages while advance = 0, holding Out and out_valid stable until out_ready.
REQ-023 SHALL sustain throughput of one result per cycle when in_valid and out_ready are held high.
REQ-024 SHALL deassert out_valid when a result is consumed and no new result is completing in stage 2.
REQ-025 SHALL perform each coefficient write on the clock edge when coef_we is high, in any cycle, independent of the handshake.
REQ-026 SHALL apply a coefficient write to products formed on later edges; a sample accepted in the same cycle uses the old coefficient.
REQ-027 SHALL ignore coefficient writes with coef_addr >= NUM_TAPS.
REQ-028 SHALL form each product at full NUM_INPUT_BITS+NUM_COEF_BITS signed width.
REQ-029 SHALL accumulate the sum at $clog2(NUM_TAPS) extra guard bits before output sizing.

Reset
REQ-030 SHALL, while rst is high, clear immediately and regardless of clk:
  - the delay line, the product registers, Out and out_valid to 0;
  - every coefficient to +1, so the default response is a NUM_TAPS-sample moving sum.
REQ-031 SHALL output in_ready = 1 on the first cycle after rst deasserts.
REQ-032 SHALL discard any in-flight sample and stall state when reset is asserted mid-operation.

Configuration
REQ-033 SHALL, when FIR_PROG_SATURATE_EN is defined, clamp a guarded sum outside the NUM_OUTPUT_BITS signed range to the maximum or minimum representable value.
REQ-034 SHALL, when FIR_PROG_SATURATE_EN is undefined, truncate the guarded sum to NUM_OUTPUT_BITS (two's-complement wrap).
REQ-035 SHALL produce identical results with or without FIR_PROG_SATURATE_EN whenever the sum is in range.

Structure
REQ-036 SHALL take from shared package fir_pkg:
  - the default widths and tap count;
  - the coefficient reset value;
  - a function for guard-bit width.
REQ-037 SHALL place one product-register lane in sub-module fir_tap (coefficient register, multiply, stage-1 register); fir_prog instantiates NUM_TAPS of them and the adder tree.
REQ-038 SHALL build all registers from the codebase register library (REGISTER_R family), with asynchronous reset.

Verification
REQ-039 SHALL verify the reset default: samples 1,2,3,4,5 with out_ready=1 and default coefficients -> Out = 1,3,6,10,15 on cycles 2..6 after the first accept.
REQ-040 SHALL verify impulse response: write coef = {2,-1,3,0,1}, then samples 1,0,0,0,0,0 -> Out sequence 2,-1,3,0,1,0.
REQ-041 SHALL verify backpressure: hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 in the stall cycles, Out stable, no sample lost or duplicated.
REQ-042 SHALL verify saturation with NUM_OUTPUT_BITS=8, coefficients all -8, samples all -8 (guarded sum +320):
  - with FIR_PROG_SATURATE_EN defined -> Out = 127;
  - without it -> Out = 64.
REQ-043 SHALL verify write-during-accept and bad address: write coef_addr=0 with value 3 in the same cycle as sample 1 -> that result uses coef 1; the next sample uses 3; a write to addr 7 with NUM_TAPS=5 has no effect.
REQ-044 SHALL verify async reset: assert rst mid-stream between clock edges -> out_valid and Out are 0 immediately, and coefficients return to +1.
